// File: rtl/button_pad_ctrl_pkg.sv
// Shared definitions for the button pad controller.
//   - key_state_e : per-channel debounce/repeat FSM encoding
//   - DEF_*       : default parameter values
//   - cnt_width() : width of a counter that must hold the largest count
//   - id_width()  : width of a channel index (minimum 1)
package button_pad_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HOLD        = 3'd2,
        ST_REPEAT      = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } key_state_e;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_DEB_CYCLES    = 1000000;
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

    // Terminal counts are always one below their parameter, so
    // $clog2 of the largest parameter is enough bits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_pad_ctrl_key_channel.sv
// key_channel: one button channel.
// Two-flop synchronizer, optional inversion, then a debounce / hold /
// auto-repeat FSM with a single shared saturating counter.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   btn_raw        raw asynchronous button input
//   level          debounced pressed state
//   press          one-cycle pulse on accepted press and on each repeat
//   rel            one-cycle pulse on accepted release
// DEB_CYCLES must be at least 2.
module key_channel
    import button_pad_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter bit REP_EN        = 1'b1,
    parameter int CW            = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rel
);

    // The sample that moves the FSM out of IDLE/HOLD/REPEAT already counts
    // as the first stable sample, so a debounce state exits when the counter
    // is one short of DEB_CYCLES-1: DEB_CYCLES samples in total.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 2);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          in_s;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          from_rep_q, from_rep_d;   // DEB_RELEASE came from REPEAT
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    assign in_s  = sync2_q ^ ACTIVE_LOW;
    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            from_rep_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            from_rep_q <= from_rep_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        from_rep_d = from_rep_q;
        level_d    = level_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!in_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (!in_s) begin
                    state_d    = ST_DEB_RELEASE;
                    cnt_d      = '0;
                    from_rep_d = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    // With repeat disabled the counter parks at terminal.
                    if (REP_EN) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REPEAT: begin
                if (!in_s) begin
                    state_d    = ST_DEB_RELEASE;
                    cnt_d      = '0;
                    from_rep_d = 1'b1;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DEB_RELEASE: begin
                if (in_s) begin
                    state_d = from_rep_q ? ST_REPEAT : ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_pad_ctrl.sv
// button_pad_ctrl: N_CH debounced buttons with auto-repeat and an event queue.
// Each channel's press pulses set a pending bit; the lowest pending channel
// is presented on a valid/ready event port. Lost presses set sticky overrun.
// Ports:
//   clk, reset          clock, async active-low reset
//   btn_in              raw button inputs
//   level               debounced pressed state
//   press               pulse on accepted press / repeat
//   release_pulse       pulse on accepted release ("release" is a reserved word)
//   evt_valid/evt_id    event presented; evt_ready accepts it
//   overrun             sticky per-channel lost-event flag; clr_ovr clears
module button_pad_ctrl
    import button_pad_ctrl_pkg::*;
#(
    parameter int              N_CH          = DEF_N_CH,
    parameter int              DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int              HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int              REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit              ACTIVE_LOW    = 1'b0,
    parameter logic [N_CH-1:0] REPEAT_EN     = '1,
    localparam int             IDW           = id_width(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic            evt_valid,
    output logic [IDW-1:0]  evt_id,
    input  logic            evt_ready,
    output logic [N_CH-1:0] overrun,
    input  logic            clr_ovr
);

    localparam int CW = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        key_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REP_EN       (REPEAT_EN[g]),
            .CW           (CW)
        ) u_ch (
            .clk    (clk),
            .rst_n  (reset),
            .btn_raw(btn_in[g]),
            .level  (level[g]),
            .press  (press[g]),
            .rel    (release_pulse[g])
        );
    end

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic            evt_valid_q, evt_valid_d;
    logic [IDW-1:0]  evt_id_q, evt_id_d;
    logic [N_CH-1:0] sel_oh, clr_mask;
    logic [IDW-1:0]  sel_id;
    logic            sel_found, load;

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
        end
    end

    always_comb begin
        // Lowest-index pending channel: scan downward so the last hit wins.
        sel_found = 1'b0;
        sel_id    = '0;
        sel_oh    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_found = 1'b1;
                sel_id    = IDW'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end

        // The slot reloads when empty or when its event transfers this
        // cycle, giving back-to-back events with no bubble.
        load        = !evt_valid_q || evt_ready;
        clr_mask    = '0;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        if (load) begin
            evt_valid_d = sel_found;
            if (sel_found) begin
                evt_id_d = sel_id;
                clr_mask = sel_oh;
            end
        end

        // A press landing on the cycle its pending bit is loaded keeps the
        // bit set, and is not an overrun since the older event was taken.
        pending_d = (pending_q & ~clr_mask) | press;
        overrun_d = (clr_ovr ? '0 : overrun_q) | (press & pending_q & ~clr_mask);
    end

endmodule

// File: tb/tb_button_pad_ctrl.sv
module tb_button_pad_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] level, press, release_pulse, overrun;
    logic       evt_valid, evt_ready, clr_ovr;
    logic [1:0] evt_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_pad_ctrl #(
        .N_CH         (4),
        .DEB_CYCLES   (4),
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(8),
        .ACTIVE_LOW   (1'b0),
        .REPEAT_EN    (4'b0100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .evt_valid    (evt_valid),
        .evt_id       (evt_id),
        .evt_ready    (evt_ready),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr)
    );

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic       vld;
        logic [1:0] id;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] b, input logic r, input logic [3:0] l,
                                input logic [3:0] p, input logic [3:0] rl,
                                input logic v, input logic [1:0] id);
        vec_t x;
        x.btn = b; x.rdy = r; x.lvl = l; x.prs = p; x.rel = rl; x.vld = v; x.id = id;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        btn_in    = 4'b0000;
        evt_ready = 1'b1;
        clr_ovr   = 1'b0;
        repeat (12) tick();
        evt_ready = 1'b0;
        chk("settle_level", 32'(level), 32'h0);
        chk("settle_valid", 32'(evt_valid), 32'h0);
    endtask

    vec_t tbl[17];
    int   p2[$];
    int   c3;
    logic [3:0] bseq [4];

    initial begin
        // Clean press on channel 1: step k is the state after edge k.
        tbl[0]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[1]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[2]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[3]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[4]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[5]  = mk(4'b0010, 0, 4'b0010, 4'b0010, 4'b0000, 0, 2'd0);
        tbl[6]  = mk(4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[7]  = mk(4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[8]  = mk(4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[9]  = mk(4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[10] = mk(4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[11] = mk(4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[12] = mk(4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[13] = mk(4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[14] = mk(4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1);
        tbl[15] = mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1);
        tbl[16] = mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);

        reset = 1'b0; btn_in = 4'b0000; evt_ready = 1'b0; clr_ovr = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({level, press, release_pulse, evt_valid, evt_id, overrun}), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            btn_in    = tbl[i].btn;
            evt_ready = tbl[i].rdy;
            tick();
            chk($sformatf("clean_press_step%0d", i + 1),
                32'({level, press, release_pulse, evt_valid, evt_id & {2{evt_valid}}, overrun}),
                32'({tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].vld, tbl[i].id & {2{tbl[i].vld}}, 4'b0000}));
        end
        evt_ready = 1'b0;

        // Bounce on channel 0, then a steady high.
        bseq[0] = 4'b0001; bseq[1] = 4'b0000; bseq[2] = 4'b0001; bseq[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            btn_in = bseq[i];
            tick();
            chk("bounce_toggle_press", 32'(press), 32'h0);
        end
        btn_in = 4'b0001;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk($sformatf("bounce_hold_t%0d", t), 32'(press), (t == 6) ? 32'h1 : 32'h0);
        end
        settle();

        // Simultaneous presses on 3 and 0, consumer stalled.
        btn_in = 4'b1001;
        repeat (6) tick();
        chk("hs_press", 32'(press), 32'h9);
        tick();
        chk("hs_valid_t7", 32'(evt_valid), 32'h0);
        for (int t = 8; t <= 12; t++) begin
            tick();
            chk($sformatf("hs_stall_t%0d", t), 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));
        end
        evt_ready = 1'b1;
        tick();
        chk("hs_second", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd3}));
        tick();
        chk("hs_drained", 32'(evt_valid), 32'h0);
        settle();

        // Auto-repeat on channel 2, repeat disabled on channel 3. The hold
        // ends between the fifth and sixth repeat slot.
        evt_ready = 1'b1;
        btn_in = 4'b1100;
        c3 = 0;
        for (int t = 1; t <= 64; t++) begin
            if (t == 53) btn_in = 4'b0000;
            tick();
            if (press[2]) p2.push_back(t);
            if (press[3]) c3++;
        end
        chk("rep_count_ch2", 32'(p2.size()), 32'd5);
        chk("rep_count_ch3", 32'(c3), 32'd1);
        if (p2.size() == 5) begin
            chk("rep_t0", 32'(p2[0]), 32'd6);
            chk("rep_t1", 32'(p2[1]), 32'd26);
            chk("rep_t2", 32'(p2[2]), 32'd34);
            chk("rep_t3", 32'(p2[3]), 32'd42);
            chk("rep_t4", 32'(p2[4]), 32'd50);
        end
        settle();

        // Overrun on channel 2 with the consumer stalled.
        btn_in = 4'b0100;
        for (int t = 1; t <= 36; t++) begin
            tick();
            if (t == 30) chk("ovr_before", 32'(overrun), 32'h0);
        end
        chk("ovr_set", 32'(overrun), 32'h4);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);
        repeat (5) tick();   // now after edge 42: repeat press is high
        chk("ovr_press42", 32'(press), 32'h4);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_new_wins", 32'(overrun), 32'h4);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared2", 32'(overrun), 32'h0);

        // Reset while channel 2 sits in REPEAT.
        repeat (3) tick();
        chk("pre_reset_level", 32'(level), 32'h4);
        reset = 1'b0;
        #1;
        chk("reset_async", 32'({level, press, release_pulse, evt_valid, evt_id, overrun}), 32'h0);
        repeat (3) tick();
        chk("reset_held", 32'({level, press, release_pulse, evt_valid, evt_id, overrun}), 32'h0);
        reset = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk($sformatf("rerun_t%0d", t), 32'({level[2], press[2], release_pulse[2]}),
                32'({(t >= 6) ? 1'b1 : 1'b0, (t == 6) ? 1'b1 : 1'b0, 1'b0}));
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
